uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_parity_calc.sv | 23 ++
 rtl/uart_tx_framer.sv | 123 ++++++++++++
 tb/tb_uart_tx_framer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit framer: FSM encoding, parity
// type codes and the legal parameter ranges.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR reduction of the payload, seeded with
// 1 for odd parity so the same chain serves both types.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  logic [DATA_WIDTH:0] chain;

  assign chain[0] = (par_typ == PAR_ODD);

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_xor
    assign chain[gi+1] = chain[gi] ^ data[gi];
  end

  assign parity = chain[DATA_WIDTH];

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: latches a payload on accept, waits in ARM for the next
// baud tick, then shifts out start, data (LSB first), optional parity and stop.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BAUD_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Frame_Done
);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_params
    $error("uart_tx_framer: illegal DATA_WIDTH or STOP_BITS");
  end

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  stop_cnt_reg, stop_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg;
  logic                  parity_reg;
  logic                  parity_calc;
  logic                  tx_reg, tx_next;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  accept;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (P_DATA),
    .par_typ(PAR_TYP),
    .parity (parity_calc)
  );

  assign accept = (state_reg == IDLE) && Data_Valid;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    tx_next       = 1'b1;
    case (state_reg)
      IDLE:    if (Data_Valid) state_next = ARM;
      ARM:     if (BAUD_TICK) state_next = START;
      START:   if (BAUD_TICK) state_next = DATA;
      DATA: begin
        if (BAUD_TICK) begin
          if (bit_cnt_reg == CNT_LAST) begin
            bit_cnt_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      PARITY:  if (BAUD_TICK) state_next = STOP;
      STOP: begin
        if (BAUD_TICK) begin
          if (stop_cnt_reg == STOP_LAST) begin
            stop_cnt_next = 1'b0;
            state_next    = IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Line level is derived from the state being entered so TX_OUT is a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[bit_cnt_next];
      PARITY:  tx_next = parity_reg;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_reg       <= tx_next;
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_reg == STOP) && (state_next == IDLE);
      if (accept) begin
        data_reg   <= P_DATA;
        par_en_reg <= PAR_EN;
        parity_reg <= parity_calc;
      end
    end
  end

  assign TX_OUT     = tx_reg;
  assign Busy       = busy_reg;
  assign Frame_Done = done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: a table of single frames on a 1-stop and
// a 2-stop instance, plus hand sequences for reset, back-to-back and tick timing.
module tb_uart_tx_framer;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_s1, busy_s1, done_s1;
  logic       tx_s2, busy_s2, done_s2;
  logic       sel;
  logic       tx_mon, busy_mon, done_mon;

  int n_vec;
  int n_fail;
  int phase;

  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_s1 (
    .CLK(clk), .RST(rst), .BAUD_TICK(baud_tick), .P_DATA(p_data),
    .Data_Valid(data_valid), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .TX_OUT(tx_s1), .Busy(busy_s1), .Frame_Done(done_s1)
  );

  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_s2 (
    .CLK(clk), .RST(rst), .BAUD_TICK(baud_tick), .P_DATA(p_data),
    .Data_Valid(data_valid), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .TX_OUT(tx_s2), .Busy(busy_s2), .Frame_Done(done_s2)
  );

  assign tx_mon   = sel ? tx_s2   : tx_s1;
  assign busy_mon = sel ? busy_s2 : busy_s1;
  assign done_mon = sel ? done_s2 : done_s1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic        sel;
    int          mid_dv;
    int          exp_n;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
    phase     = (phase + 1) % 4;
    baud_tick = (phase == 3);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs from just after accept until Frame_Done; bit i of bits is the line
  // level seen during the i-th tick interval starting with the start bit.
  task automatic run_frame(input int budget, input int mid_dv,
                           output logic [15:0] bits, output int nbits,
                           output int ndone, output int busy_low,
                           output int pre_len, output int start_len);
    bit started;
    bit start_over;
    bits = '0; nbits = 0; ndone = 0; busy_low = 0; pre_len = 0; start_len = 0;
    started = 1'b0; start_over = 1'b0;
    for (int c = 0; c < budget && ndone == 0; c++) begin
      if (!started && tx_mon == 1'b0) started = 1'b1;
      if (!started) pre_len++;
      if (started && !start_over) begin
        if (tx_mon == 1'b0) start_len++;
        else start_over = 1'b1;
      end
      if (started && baud_tick && nbits < 16) begin
        bits[nbits] = tx_mon;
        nbits++;
      end
      if (busy_mon !== 1'b1) busy_low++;
      if (mid_dv >= 0) data_valid = (c == mid_dv);
      if (c == mid_dv) begin
        p_data  = ~p_data;
        par_en  = ~par_en;
        par_typ = ~par_typ;
      end
      step();
      if (done_mon === 1'b1) ndone++;
    end
  endtask

  task automatic idle_window(input int cycles, output int bad);
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (busy_mon !== 1'b0 || tx_mon !== 1'b1 || done_mon !== 1'b0) bad++;
    end
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] d, input logic pe,
                                input logic pt, input int exp_n, input logic [15:0] exp_bits);
    logic [15:0] bits;
    int nbits, ndone, busy_low, pre_len, start_len;
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    run_frame(120, -1, bits, nbits, ndone, busy_low, pre_len, start_len);
    $display("%s: data=%02h ticks=%0d line=%04h done=%0d", tag, d, nbits, bits, ndone);
    check({tag, "_ticks"}, nbits, exp_n);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_done"}, ndone, 1);
  endtask

  initial begin
    logic [15:0] bits;
    int nbits, ndone, busy_low, pre_len, start_len, bad, ticks, dones;

    vecs[0] = '{data: 8'hA5, par_en: 1'b1, par_typ: 1'b0, sel: 1'b0, mid_dv: 20, exp_n: 11, exp_bits: 16'h054A};
    vecs[1] = '{data: 8'h00, par_en: 1'b1, par_typ: 1'b1, sel: 1'b1, mid_dv: -1, exp_n: 12, exp_bits: 16'h0E00};
    vecs[2] = '{data: 8'hFF, par_en: 1'b0, par_typ: 1'b0, sel: 1'b0, mid_dv: 15, exp_n: 10, exp_bits: 16'h03FE};
    vecs[3] = '{data: 8'h3C, par_en: 1'b1, par_typ: 1'b1, sel: 1'b0, mid_dv: -1, exp_n: 11, exp_bits: 16'h0678};
    vecs[4] = '{data: 8'h01, par_en: 1'b1, par_typ: 1'b0, sel: 1'b1, mid_dv: -1, exp_n: 12, exp_bits: 16'h0E02};
    vecs[5] = '{data: 8'h80, par_en: 1'b0, par_typ: 1'b0, sel: 1'b1, mid_dv: 25, exp_n: 11, exp_bits: 16'h0700};

    n_vec = 0; n_fail = 0; phase = 0;
    rst = 1'b1; baud_tick = 1'b0; p_data = '0; data_valid = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; sel = 1'b0;

    // Reset state of both instances
    step();
    check("rst_tx_s1", tx_s1, 1'b1);
    check("rst_busy_s1", busy_s1, 1'b0);
    check("rst_done_s1", done_s1, 1'b0);
    check("rst_tx_s2", tx_s2, 1'b1);
    check("rst_busy_s2", busy_s2, 1'b0);
    check("rst_done_s2", done_s2, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      do_reset();
      p_data = vecs[i].data; par_en = vecs[i].par_en; par_typ = vecs[i].par_typ;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      run_frame(120, vecs[i].mid_dv, bits, nbits, ndone, busy_low, pre_len, start_len);
      data_valid = 1'b0;
      $display("vec %0d: data=%02h par_en=%0b par_typ=%0b stop=%0d ticks=%0d line=%04h done=%0d",
               i, vecs[i].data, vecs[i].par_en, vecs[i].par_typ, sel ? 2 : 1, nbits, bits, ndone);
      check($sformatf("vec%0d_ticks", i), nbits, vecs[i].exp_n);
      check($sformatf("vec%0d_bits", i), bits, vecs[i].exp_bits);
      check($sformatf("vec%0d_done", i), ndone, 1);
      check($sformatf("vec%0d_busy", i), busy_low, 0);
      idle_window(12, bad);
      check($sformatf("vec%0d_idle_after", i), bad, 0);
    end

    // Tick coincident with the accept cycle: ARM and START each span a full tick period
    sel = 1'b0;
    do_reset();
    for (int g = 0; g < 8 && !baud_tick; g++) step();
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    run_frame(120, -1, bits, nbits, ndone, busy_low, pre_len, start_len);
    $display("coincident tick: arm=%0d start=%0d ticks=%0d line=%04h", pre_len, start_len, nbits, bits);
    check("coinc_arm_len", pre_len, 4);
    check("coinc_start_len", start_len, 4);
    check("coinc_bits", bits, 16'h054A);

    // Data_Valid held high across three frames, P_DATA changed after each accept
    do_reset();
    par_en = 1'b1; par_typ = 1'b0; p_data = 8'hA5; data_valid = 1'b1;
    step();
    p_data = 8'h3C;
    run_frame(120, -1, bits, nbits, ndone, busy_low, pre_len, start_len);
    $display("b2b frame 1: ticks=%0d line=%04h", nbits, bits);
    check("b2b1_bits", bits, 16'h054A);
    check("b2b1_done", ndone, 1);
    dones = ndone;
    step();
    p_data = 8'hFF;
    run_frame(120, -1, bits, nbits, ndone, busy_low, pre_len, start_len);
    $display("b2b frame 2: ticks=%0d line=%04h", nbits, bits);
    check("b2b2_bits", bits, 16'h0478);
    check("b2b2_busy", busy_low, 0);
    dones += ndone;
    step();
    p_data = 8'h00;
    run_frame(120, -1, bits, nbits, ndone, busy_low, pre_len, start_len);
    data_valid = 1'b0;
    $display("b2b frame 3: ticks=%0d line=%04h", nbits, bits);
    check("b2b3_bits", bits, 16'h05FE);
    dones += ndone;
    check("b2b_done_count", dones, 3);

    // Reset during data bit 3 aborts the frame cleanly
    do_reset();
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    ticks = 0;
    for (int c = 0; c < 100 && ticks < 5; c++) begin
      if (baud_tick) ticks++;
      step();
    end
    step();
    check("mid_rst_pre_tx", tx_s1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("mid-frame reset: tx=%0b busy=%0b done=%0b", tx_s1, busy_s1, done_s1);
    check("mid_rst_tx", tx_s1, 1'b1);
    check("mid_rst_busy", busy_s1, 1'b0);
    check("mid_rst_done", done_s1, 1'b0);
    idle_window(40, bad);
    check("mid_rst_quiet", bad, 0);
    send_and_check("post_rst", 8'h3C, 1'b1, 1'b1, 11, 16'h0678);

    // Reset wins over Data_Valid and BAUD_TICK in the same cycle
    for (int g = 0; g < 8 && !baud_tick; g++) step();
    rst = 1'b1; data_valid = 1'b1;
    step();
    check("rst_prec_busy", busy_s1, 1'b0);
    rst = 1'b0; data_valid = 1'b0;
    step();
    $display("reset precedence: busy=%0b tx=%0b", busy_s1, tx_s1);
    check("rst_prec_busy_after", busy_s1, 1'b0);
    check("rst_prec_tx", tx_s1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
